// File: rtl/bus_share_pkg.sv
// Shared constants and helpers for the bus_share_arbiter codebase slice.
// The optional hold-limit feature is enabled with the BUS_HOLD_LIMIT_EN macro.
package bus_share_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN  = 2'd1;
    localparam logic [1:0] TURN = 2'd2;

    localparam int NUM_REQ_MIN     = 2;
    localparam int NUM_REQ_MAX     = 16;
    localparam int TURN_CYCLES_MIN = 1;
    localparam int TURN_CYCLES_MAX = 15;
    localparam int MAX_HOLD_MIN    = 1;
    localparam int MAX_HOLD_MAX    = 255;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_share_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_pick
    import bus_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic               found,
    output logic [IDW-1:0]     idx
);

    logic [NUM_REQ-1:0]   upper;
    logic [2*NUM_REQ-1:0] dbl;

    // Lower copy keeps only bits at/after the pointer; upper copy supplies the wrap.
    assign dbl = {req, upper};

    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        upper = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            upper[i] = req[i] && (i >= int'(rr_ptr));
        end
        for (int i = 2 * NUM_REQ - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                found = 1'b1;
                idx   = IDW'(i % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/bus_share_arbiter.sv
// Round-robin bus-share arbiter with registered one-hot grant and turnaround gap.
// Define BUS_HOLD_LIMIT_EN to enable forced release after MAX_HOLD grant cycles.
module bus_share_arbiter
    import bus_share_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    output logic [NUM_REQ-1:0]           grant,
    output logic [id_width(NUM_REQ)-1:0] grant_id,
    output logic                         bus_busy,
    output logic                         preempt
);

    localparam int IDW = id_width(NUM_REQ);

    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
        $error("NUM_REQ out of range");
    end
    if (TURN_CYCLES < TURN_CYCLES_MIN || TURN_CYCLES > TURN_CYCLES_MAX) begin : g_bad_turn
        $error("TURN_CYCLES out of range");
    end
    if (MAX_HOLD < MAX_HOLD_MIN || MAX_HOLD > MAX_HOLD_MAX) begin : g_bad_hold
        $error("MAX_HOLD out of range");
    end

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] next_ptr;
    logic [3:0]     turn_cnt;
    logic           found;
    logic [IDW-1:0] pick_idx;
    logic           owner_req;
    logic           release_now;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (found),
        .idx    (pick_idx)
    );

    assign owner_req = req[grant_id];
    assign next_ptr  = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef BUS_HOLD_LIMIT_EN
    logic [7:0] hold_cnt;
    logic       limit_hit;

    assign limit_hit   = (hold_cnt == 8'(MAX_HOLD - 1)) && |(req & ~grant);
    assign release_now = !owner_req || limit_hit;

    // Counter saturates at the limit so a late competitor triggers release at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            preempt <= (state == OWN) && limit_hit && owner_req;
            if (state == OWN && !release_now) begin
                if (hold_cnt != 8'(MAX_HOLD - 1)) hold_cnt <= hold_cnt + 8'd1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign release_now = !owner_req;
    assign preempt     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            bus_busy <= 1'b0;
            rr_ptr   <= '0;
            turn_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= NUM_REQ'(1) << pick_idx;
                        grant_id <= pick_idx;
                        bus_busy <= 1'b1;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (release_now) begin
                        grant    <= '0;
                        bus_busy <= 1'b0;
                        rr_ptr   <= next_ptr;
                        turn_cnt <= 4'(TURN_CYCLES - 1);
                        state    <= TURN;
                    end
                end
                TURN: begin
                    if (turn_cnt == 4'd0) state <= IDLE;
                    else                  turn_cnt <= turn_cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bus_share_arbiter.md
Name: bus_share_arbiter

Overview:
- Round-robin arbiter that shares one tri-state-free bus between N requesters.
- Each requester gates its data onto the shared bus through its own AND-enable stage; this block drives those enable lines.
- Outputs are a registered one-hot grant with a guaranteed dead (turnaround) gap between owners, so two enables are never high in the same cycle.
- Sits between requester FSMs and the per-requester enable gates feeding the shared OR-bus.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- TURN_CYCLES, 1, idle cycles with all grants low between owners (1..15).
- MAX_HOLD, 8, max consecutive grant cycles before forced release (used only with the optional feature; 1..255).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  request per requester, level, held until done.
- grant  output  NUM_REQ  registered one-hot enable per requester; drives the enable-gate inputs.
- grant_id  output  $clog2(NUM_REQ)  binary index of the current owner; valid only while bus_busy=1.
- bus_busy  output  1  OR of grant, registered.
- preempt  output  1  one-cycle pulse when an owner is forcibly released.

Behaviour:
- Interface: one clock, clk; reset asynchronous, active-low, rst_n.
- Reset values: grant=0, grant_id=0, bus_busy=0, preempt=0, state=IDLE, rr_ptr=0, turn_cnt=0, hold_cnt=0.
- States:
  - IDLE: if req!=0, pick the first set bit at or after rr_ptr, searching circularly upward with wrap from NUM_REQ-1 to 0. Load grant/grant_id at the next edge and go to OWN. If req==0, stay in IDLE.
  - Latency: a req sampled at edge k while in IDLE produces grant high after edge k, i.e. 1 cycle.
  - OWN: hold grant while req[grant_id]=1. When req[grant_id] is sampled 0, clear grant at that edge, set rr_ptr=(grant_id+1) mod NUM_REQ, load turn_cnt=TURN_CYCLES-1, and go to TURN.
  - TURN: grant=0. Decrement turn_cnt; when it is 0, go to IDLE. The minimum gap between owners is therefore TURN_CYCLES cycles with grant=0 plus the 1-cycle arbitration in IDLE.
- Invariants: grant is always one-hot or zero. grant_id and bus_busy are consistent with grant on every cycle.
- Boundary conditions:
  - A request deasserted before it is sampled in IDLE is never granted.
  - All requesters set simultaneously: grants go 0,1,2,3,0… in fair rotation.
  - A single requester re-requesting immediately is re-granted after the turnaround; rr_ptr wraps but the search finds it again.
  - req changes on non-owner lines during OWN or TURN are ignored until the next IDLE.
  - rst_n asserted mid-grant: grant drops immediately (asynchronous), and rr_ptr returns to 0.

Optional Feature:
- Macro: BUS_HOLD_LIMIT_EN.
- Defined:
  - hold_cnt counts cycles in OWN.
  - When hold_cnt reaches MAX_HOLD-1 and some other req bit is set, release as in a normal OWN exit and pulse preempt for the same cycle that grant drops.
  - With no competing request, the owner keeps the bus and hold_cnt saturates.
  - If the owner's req drops on the same edge the limit is hit, the release is normal and preempt=0.
- Undefined: no hold_cnt; preempt is tied to 0; MAX_HOLD is unused; an owner keeps the bus until its req drops.

Decomposition:
- Package bus_share_pkg holds:
  - state enum (IDLE, OWN, TURN), 2 bits;
  - width helper function for grant_id;
  - parameter legal-range constants.
- One sub-module: rr_pick, purely combinational. Inputs req and rr_ptr; outputs a found flag and a binary index. Implemented via a double-width masked priority encode.

Test Plan:
- Reset/idle: rst_n=0 then 1, req=0000 for 10 cycles -> grant=0000, bus_busy=0, preempt=0 throughout.
- Single requester: req=0100 at cycle 0 -> grant=0100, grant_id=2 at cycle 1. Drop req at cycle 5 -> grant=0000 at cycle 6; re-request regranted at cycle 8 with TURN_CYCLES=1.
- Fairness: req=1111 held, each owner drops after 3 cycles of grant -> grant order 0001,0010,0100,1000,0001. No cycle has two grant bits set, and each pair of owners is separated by ≥1 cycle of grant=0000.
- Limit (macro defined, MAX_HOLD=8): req=0011 with bit 0 never dropping -> bit 0 granted for exactly 8 cycles, preempt=1 on release, then grant=0010. With req=0001 alone, bit 0 holds indefinitely and preempt stays 0.
- Simultaneous drop and limit: owner req drops on the limit cycle -> release with preempt=0.
- Reset mid-operation: rst_n low asynchronously while grant=1000 -> grant=0000 before the next clk edge. After release, req=1001 grants 0001 first (rr_ptr back to 0).
